// File: rtl/key_bcd_entry_pkg.sv
// Shared types, defaults and BCD step helpers for the key-to-BCD entry path.
package key_bcd_entry_pkg;

  typedef enum logic {EDIT, PENDING} entry_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_pair_t;

  localparam int DEBOUNCE_DEFAULT = 4;

  // Increment a two-digit BCD value; max_value wraps to 00.
  function automatic bcd_pair_t bcd_inc(input bcd_digit_t tens, input bcd_digit_t ones,
                                        input int max_value);
    bcd_pair_t  r;
    bcd_digit_t max_t;
    bcd_digit_t max_o;
    max_t = bcd_digit_t'(max_value / 10);
    max_o = bcd_digit_t'(max_value % 10);
    if (tens == max_t && ones == max_o) begin
      r.tens = 4'd0;
      r.ones = 4'd0;
    end else if (ones == 4'd9) begin
      r.tens = tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = tens;
      r.ones = ones + 4'd1;
    end
    return r;
  endfunction

  // Decrement a two-digit BCD value; 00 wraps to max_value.
  function automatic bcd_pair_t bcd_dec(input bcd_digit_t tens, input bcd_digit_t ones,
                                        input int max_value);
    bcd_pair_t r;
    if (tens == 4'd0 && ones == 4'd0) begin
      r.tens = bcd_digit_t'(max_value / 10);
      r.ones = bcd_digit_t'(max_value % 10);
    end else if (ones == 4'd0) begin
      r.tens = tens - 4'd1;
      r.ones = 4'd9;
    end else begin
      r.tens = tens;
      r.ones = ones - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_bcd_entry_debounce.sv
// Per-key conditioning: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each debounced press (1->0).
module key_debounce
  import key_bcd_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_db;
  logic             r_db_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_expire;

  assign w_differ = (r_sync1 != r_db);
  assign w_expire = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchronize, qualify the level for DEBOUNCE_CYCLES samples, then edge-detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_db    <= 1'b1;
      r_db_d  <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= key_n;
      r_sync1 <= r_sync0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_db  <= r_sync1;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_db_d  <= r_db;
      r_press <= r_db_d & ~r_db;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/key_bcd_entry.sv
// Two-digit BCD entry: up/down edit the value, enter commits it over a
// valid/ready request; the user is locked out until the request is taken.
module key_bcd_entry
  import key_bcd_entry_pkg::*;
#(
  parameter int MAX_VALUE       = 99,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_enter_n,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [3:0] req_tens,
  output logic [3:0] req_ones,
  output logic       busy
);

  logic         w_up;
  logic         w_down;
  logic         w_enter;

  entry_state_t r_state;
  entry_state_t w_state_nxt;
  bcd_digit_t   r_tens;
  bcd_digit_t   r_ones;
  bcd_digit_t   r_req_tens;
  bcd_digit_t   r_req_ones;
  bcd_digit_t   w_tens_nxt;
  bcd_digit_t   w_ones_nxt;
  bcd_digit_t   w_req_tens_nxt;
  bcd_digit_t   w_req_ones_nxt;
  bcd_pair_t    w_inc;
  bcd_pair_t    w_dec;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .reset (reset),
    .key_n (key_up_n),
    .press (w_up)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk   (clk),
    .reset (reset),
    .key_n (key_down_n),
    .press (w_down)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .key_n (key_enter_n),
    .press (w_enter)
  );

  assign w_inc = bcd_inc(r_tens, r_ones, MAX_VALUE);
  assign w_dec = bcd_dec(r_tens, r_ones, MAX_VALUE);

  // State, edit digits and committed request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EDIT;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_req_tens <= 4'd0;
      r_req_ones <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tens     <= w_tens_nxt;
      r_ones     <= w_ones_nxt;
      r_req_tens <= w_req_tens_nxt;
      r_req_ones <= w_req_ones_nxt;
    end
  end

  // Next state and next digit/request values; enter wins over a same-cycle step.
  always_comb begin
    w_state_nxt    = r_state;
    w_tens_nxt     = r_tens;
    w_ones_nxt     = r_ones;
    w_req_tens_nxt = r_req_tens;
    w_req_ones_nxt = r_req_ones;
    case (r_state)
      EDIT: begin
        if (w_enter) begin
          w_req_tens_nxt = r_tens;
          w_req_ones_nxt = r_ones;
          w_state_nxt    = PENDING;
        end else if (w_up && !w_down) begin
          w_tens_nxt = w_inc.tens;
          w_ones_nxt = w_inc.ones;
        end else if (w_down && !w_up) begin
          w_tens_nxt = w_dec.tens;
          w_ones_nxt = w_dec.ones;
        end
      end
      PENDING: begin
        if (req_ready) begin
          w_state_nxt = EDIT;
        end
      end
      default: w_state_nxt = EDIT;
    endcase
  end

  assign bcd_tens  = r_tens;
  assign bcd_ones  = r_ones;
  assign req_tens  = r_req_tens;
  assign req_ones  = r_req_ones;
  assign req_valid = (r_state == PENDING);
  assign busy      = (r_state == PENDING);

endmodule

// File: tb/tb_key_bcd_entry.sv
// Scoreboard bench for key_bcd_entry: decimal reference model, expectations
// queued at stimulus time and compared when the outputs settle.
module tb_key_bcd_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_up_n = 1'b1;
  logic       key_down_n = 1'b1;
  logic       key_enter_n = 1'b1;
  logic       req_ready = 1'b0;
  logic [3:0] bcd_tens, bcd_ones, req_tens, req_ones;
  logic       req_valid, busy;

  logic       k15_up_n = 1'b1;
  logic [3:0] t15_tens, t15_ones, t15_rt, t15_ro;
  logic       t15_rv, t15_busy;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    string tag;
    int    tens;
    int    ones;
    int    rv;
    int    rt;
    int    ro;
  } exp_t;
  exp_t sb_q[$];

  int mv = 0, mpend = 0, mrt = 0, mro = 0;
  int mv15 = 0;

  always #5 clk = ~clk;

  key_bcd_entry #(.MAX_VALUE(99), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .key_up_n(key_up_n), .key_down_n(key_down_n),
    .key_enter_n(key_enter_n), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .req_valid(req_valid), .req_ready(req_ready), .req_tens(req_tens),
    .req_ones(req_ones), .busy(busy)
  );

  key_bcd_entry #(.MAX_VALUE(15), .DEBOUNCE_CYCLES(4)) dut15 (
    .clk(clk), .reset(reset), .key_up_n(k15_up_n), .key_down_n(1'b1),
    .key_enter_n(1'b1), .bcd_tens(t15_tens), .bcd_ones(t15_ones),
    .req_valid(t15_rv), .req_ready(1'b0), .req_tens(t15_rt),
    .req_ones(t15_ro), .busy(t15_busy)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.tens = mv / 10; e.ones = mv % 10;
    e.rv = mpend; e.rt = mrt; e.ro = mro;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".tens"}, int'(bcd_tens), e.tens);
      check_eq({e.tag, ".ones"}, int'(bcd_ones), e.ones);
      check_eq({e.tag, ".req_valid"}, int'(req_valid), e.rv);
      check_eq({e.tag, ".busy"}, int'(busy), e.rv);
      check_eq({e.tag, ".req_tens"}, int'(req_tens), e.rt);
      check_eq({e.tag, ".req_ones"}, int'(req_ones), e.ro);
    end
  endtask

  task automatic model_keys(input logic [2:0] m);
    if (mpend == 0) begin
      if (m[2]) begin
        mrt = mv / 10; mro = mv % 10; mpend = 1;
      end else if (m[0] && !m[1]) begin
        mv = (mv == 99) ? 0 : mv + 1;
      end else if (m[1] && !m[0]) begin
        mv = (mv == 0) ? 99 : mv - 1;
      end
    end
  endtask

  // m[0]=up, m[1]=down, m[2]=enter; all selected keys go low together.
  task automatic press_keys(input logic [2:0] m, input string tag);
    @(posedge clk); #1;
    key_up_n = ~m[0]; key_down_n = ~m[1]; key_enter_n = ~m[2];
    model_keys(m);
    push_exp(tag);
    repeat (10) @(posedge clk);
    #1;
    key_up_n = 1'b1; key_down_n = 1'b1; key_enter_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic ready_pulse(input string tag);
    @(posedge clk); #1;
    req_ready = 1'b1;
    push_exp({tag, ".before"});
    @(negedge clk);
    check_out();
    if (mpend != 0) mpend = 0;
    push_exp({tag, ".after"});
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    check_out();
  endtask

  task automatic press15();
    @(posedge clk); #1;
    k15_up_n = 1'b0;
    mv15 = (mv15 == 15) ? 0 : mv15 + 1;
    repeat (10) @(posedge clk);
    #1;
    k15_up_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push_exp("reset");
    @(negedge clk);
    check_out();

    // Press latency: key low before edge N, pulse after N+6, digits after N+7
    @(posedge clk); #1;
    key_up_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 5) check_eq("lat.press_n5", int'(dut.u_up.press), 0);
      if (k == 6) begin
        check_eq("lat.press_n6", int'(dut.u_up.press), 1);
        check_eq("lat.ones_n6", int'(bcd_ones), 0);
      end
      if (k == 7) begin
        check_eq("lat.press_n7", int'(dut.u_up.press), 0);
        mv = 1;
        push_exp("lat.n7");
        check_out();
      end
    end
    repeat (50) @(posedge clk);
    push_exp("lat.held");
    @(negedge clk);
    check_out();
    #1 key_up_n = 1'b1;
    repeat (10) @(posedge clk);

    // Bounce shorter than the debounce window
    @(posedge clk); #1;
    push_exp("bounce");
    for (int b = 0; b < 5; b++) begin
      key_up_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 key_up_n = 1'b1;
      @(posedge clk); #1;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_out();

    // Wrap and carry/borrow
    press_keys(3'b010, "wrap.to0");
    for (int i = 0; i < 9; i++) press_keys(3'b001, "wrap.up");
    press_keys(3'b001, "wrap.carry");
    for (int i = 0; i < 10; i++) press_keys(3'b010, "wrap.dn");
    press_keys(3'b010, "wrap.under");

    // Handshake at 42
    press_keys(3'b001, "hs.up99");
    for (int i = 0; i < 42; i++) press_keys(3'b001, "hs.to42");
    ready_pulse("hs.ready_edit");
    press_keys(3'b100, "hs.enter");
    press_keys(3'b001, "hs.up_ignored");
    press_keys(3'b100, "hs.enter_ignored");
    ready_pulse("hs.accept");
    press_keys(3'b001, "hs.up43");

    // Simultaneous events at 07
    for (int i = 0; i < 36; i++) press_keys(3'b010, "sim.to07");
    press_keys(3'b101, "sim.up_enter");
    ready_pulse("sim.accept");
    press_keys(3'b011, "sim.up_down");

    // Reset while pending with down held through reset
    press_keys(3'b100, "rp.enter");
    @(posedge clk); #1;
    key_down_n = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mv = 0; mpend = 0; mrt = 0; mro = 0;
    push_exp("rp.after_reset");
    @(negedge clk);
    check_out();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) begin
        push_exp("rp.n6");
        check_out();
      end
      if (k == 7) begin
        mv = 99;
        push_exp("rp.n7");
        check_out();
      end
    end
    repeat (30) @(posedge clk);
    #1 key_down_n = 1'b1;
    repeat (10) @(posedge clk);
    push_exp("rp.once");
    @(negedge clk);
    check_out();

    // MAX_VALUE=15 instance wraps 15 -> 00
    for (int i = 0; i < 15; i++) press15();
    check_eq("m15.tens_at15", int'(t15_tens), mv15 / 10);
    check_eq("m15.ones_at15", int'(t15_ones), mv15 % 10);
    press15();
    check_eq("m15.tens_wrap", int'(t15_tens), mv15 / 10);
    check_eq("m15.ones_wrap", int'(t15_ones), mv15 % 10);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_bcd_entry.md
Name: key_bcd_entry

Overview:
- User-input side of the 7-segment display path: turns raw DE1 pushbuttons into a two-digit BCD value, which the existing seg7 decoder renders.
- Three active-low keys (up, down, enter) are synchronized, debounced and edge-detected. Up and down step the value; enter commits it as a request over a valid/ready handshake, e.g. the target floor for the elevator controller.
- Sits between KEY[3:1] and the controller; bcd_tens/bcd_ones also feed seg7 instances directly.

Parameters:
- MAX_VALUE, 99, largest enterable value (legal 1..99); wrap point for up/down.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a debounced level changes (legal 2..2^20).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- key_up_n  input  1  raw up button, active-low, asynchronous to clk.
- key_down_n  input  1  raw down button, active-low, asynchronous.
- key_enter_n  input  1  raw enter button, active-low, asynchronous.
- bcd_tens  output  4  tens digit of value being edited (0..9).
- bcd_ones  output  4  ones digit of value being edited (0..9).
- req_valid  output  1  committed request pending.
- req_ready  input  1  consumer accepts the request when high with req_valid.
- req_tens  output  4  committed tens digit; stable while req_valid.
- req_ones  output  4  committed ones digit; stable while req_valid.
- busy  output  1  high in PENDING; the user is locked out.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (reset). All state updates on the rising clk edge.
- Reset values: bcd_tens=0, bcd_ones=0, req_valid=0, req_tens=0, req_ones=0, busy=0, state=EDIT. Every debouncer has its synchronizer flops=1, debounced level=1 (released) and counter=0.
- Synchronizer: 2-flop chain per key.
- Debounce:
  - The counter increments each edge on which the synced sample differs from the debounced level. It clears to 0 whenever they agree.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no change.
- Press event: a 1-cycle registered pulse on a debounced 1->0 transition. A release produces no event.
  - Latency: key held low from before edge N gives synced low after edge N+1, debounced low after edge N+1+DEBOUNCE_CYCLES, and the press pulse high for the cycle after edge N+2+DEBOUNCE_CYCLES.
  - Holding a key produces exactly one event (no auto-repeat).
- Value: held internally as BCD digits; digit arithmetic is done in BCD, never binary.
  - Up: value+1; MAX_VALUE wraps to 0. Ones 9 carries into tens.
  - Down: value-1; 0 wraps to MAX_VALUE. Ones 0 borrows from tens (ones becomes 9).
  - Up and down in the same cycle: no change.
  - The digit outputs update on the edge after the event.
- FSM states: EDIT, PENDING.
  - EDIT, enter event: req_tens/req_ones latch the current value (the pre-update value if up/down arrives in the same cycle; that up/down is discarded). req_valid=1, busy=1, next=PENDING.
  - PENDING: up, down and enter events are discarded. bcd_* and req_* are held.
  - PENDING with req_valid && req_ready at an edge: req_valid=0, busy=0, next=EDIT. req_tens/req_ones keep their last value.
  - req_ready while in EDIT has no effect.
  - The value is not cleared after a commit; the user edits from the last value.
- Reset mid-operation: reset overrides everything, including a pending request, which is dropped. A key still held low through reset produces one press event, with full latency measured from the first edge after reset deasserts.
- No combinational path from any input to any output.

Decomposition:
- Package key_bcd_entry_pkg:
  - typedef enum logic {EDIT, PENDING} entry_state_t;
  - typedef logic [3:0] bcd_digit_t;
  - DEBOUNCE_DEFAULT=4;
  - pure functions bcd_inc and bcd_dec, taking (tens, ones, max) and returning the wrapped digit pair.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, key_n, press). Contains the synchronizer, counter and edge pulse; instanced 3 times. The top holds the digit registers, FSM and request registers.

Test Plan:
- Reset, then hold key_up_n low from before edge 10 (DEBOUNCE_CYCLES=4) -> single press pulse in the cycle after edge 16; bcd_tens=0, bcd_ones=1 after edge 17; no further change while held for 50 cycles.
- Bounce: key_up_n toggles low 3 cycles / high 1 cycle, repeated 5x, then stays high -> no press event; value unchanged.
- Wrap: 9 up presses from 0 -> digits 0,9; one more -> 1,0; from 0 one down -> 9,9 (MAX_VALUE=99). With MAX_VALUE=15: at 15, up -> 0.
- Handshake: value 42, press enter with req_ready=0 -> req_valid=1, req=4,2, busy=1. An up press during PENDING is ignored (still 4,2). Raising req_ready for one cycle -> req_valid=0 next edge; then up -> 4,3.
- Simultaneous: up and enter debounced on the same edge at value 07 -> request 0,7; bcd stays 0,7. Up and down simultaneous at 07 -> stays 07.
- Reset while PENDING with key_down_n held low -> all outputs 0, req_valid=0. Exactly one down event after full latency; value becomes 9,9.
